// File: rtl/clk_mux_pkg.sv
// ----------------------------------------------------------------------------
// clk_mux_pkg
//   Shared constants for the glitch-free clock multiplexer.
//   CLK_MUX_SYNC_STAGES_DEF : default synchronizer depth per channel
//   CLK_MUX_SYNC_STAGES_MIN : smallest depth the channel will build
// ----------------------------------------------------------------------------
package clk_mux_pkg;

   localparam int CLK_MUX_SYNC_STAGES_DEF = 2;
   localparam int CLK_MUX_SYNC_STAGES_MIN = 2;

   // Requested depths below the minimum are raised to it.
   function automatic int clk_mux_stages(input int req);
      return (req < CLK_MUX_SYNC_STAGES_MIN) ? CLK_MUX_SYNC_STAGES_MIN : req;
   endfunction

endpackage

// File: rtl/clk_mux_if.sv
// ----------------------------------------------------------------------------
// clk_mux_if
//   Select/output bundle of the clock multiplexer.
//   i_sel : clock select, asynchronous to both input clocks (0 -> clk0)
//   o_clk : multiplexed clock
//   master : the side that drives the select and consumes the clock
//   slave  : the multiplexer itself
// ----------------------------------------------------------------------------
interface clk_mux_if;

   logic i_sel;
   logic o_clk;

   modport master (output i_sel, input  o_clk);
   modport slave  (input  i_sel, output o_clk);

endinterface

// File: rtl/clk_mux_chan.sv
// ----------------------------------------------------------------------------
// clk_mux_chan
//   One channel of the glitch-free clock mux: optional reset synchronizer,
//   request synchronizer, falling-edge enable flop and the clock gate.
//   clk_i   : this channel's source clock
//   rstn_i  : active-low synchronous reset (resynchronized when RST_SYNC=1)
//   req_i   : request to enable this clock (asynchronous)
//   en_o    : enable, changes only while clk_i is low
//   clk_o   : clk_i gated by en_o
// ----------------------------------------------------------------------------
module clk_mux_chan
   import clk_mux_pkg::*;
#(
   parameter int SYNC_STAGES = CLK_MUX_SYNC_STAGES_DEF,
   parameter bit RST_SYNC    = 1'b0
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic req_i,
   output logic en_o,
   output logic clk_o
);

   localparam int STAGES = clk_mux_stages(SYNC_STAGES);

   logic              rst_n;
   logic [STAGES-1:0] sync_q, sync_d;
   logic              en_q, en_d;

   generate
      if (RST_SYNC) begin : g_rst_sync
         logic [STAGES-1:0] rst_q, rst_d;

         // Assertion clears every stage at once; release ripples a 1 through.
         always_comb begin
            rst_d = {rst_q[STAGES-2:0], 1'b1};
         end

         always_ff @(posedge clk_i) begin
            if (!rstn_i) rst_q <= '0;
            else         rst_q <= rst_d;
         end

         assign rst_n = rst_q[STAGES-1];
      end else begin : g_rst_direct
         // Reset already belongs to this clock domain.
         assign rst_n = rstn_i;
      end
   endgenerate

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], req_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   // Enable moves on the falling edge so the gate only opens or closes
   // while the source clock is low. It has no reset of its own: it copies
   // the synchronizer, which clears on the preceding rising edge.
   always_comb begin
      en_d = sync_q[STAGES-1];
   end

   always_ff @(negedge clk_i) begin
      en_q <= en_d;
   end

   assign en_o  = en_q;
   assign clk_o = clk_i & en_q;

endmodule

// File: rtl/clk_mux.sv
// ----------------------------------------------------------------------------
// clk_mux
//   Glitch-free 2:1 clock multiplexer using a cross-coupled enable handshake.
//   A channel may only request its clock once the other channel's enable has
//   dropped, so the enables never overlap and no output phase is shortened.
//   i_clk0 : clock 0, also the domain in which i_rstn is sampled
//   i_clk1 : clock 1, gets i_rstn through a local reset synchronizer
//   i_rstn : active-low synchronous reset
//   bus    : i_sel in (0 -> clk0, 1 -> clk1), o_clk out
//   A switch away from a stopped clock never completes.
// ----------------------------------------------------------------------------
module clk_mux
   import clk_mux_pkg::*;
#(
   parameter int SYNC_STAGES = CLK_MUX_SYNC_STAGES_DEF
) (
   input  logic     i_clk0,
   input  logic     i_clk1,
   input  logic     i_rstn,
   clk_mux_if.slave bus
);

   logic req0, req1;
   logic en0,  en1;
   logic gclk0, gclk1;

   // Cross-coupling: each request waits for the other enable to fall.
   assign req0 = ~bus.i_sel & ~en1;
   assign req1 =  bus.i_sel & ~en0;

   clk_mux_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_SYNC    (1'b0)
   ) u_chan0 (
      .clk_i  (i_clk0),
      .rstn_i (i_rstn),
      .req_i  (req0),
      .en_o   (en0),
      .clk_o  (gclk0)
   );

   clk_mux_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_SYNC    (1'b1)
   ) u_chan1 (
      .clk_i  (i_clk1),
      .rstn_i (i_rstn),
      .req_i  (req1),
      .en_o   (en1),
      .clk_o  (gclk1)
   );

   assign bus.o_clk = gclk0 | gclk1;

endmodule

// File: tb/tb_clk_mux.sv
`timescale 1ns/1ps
module tb_clk_mux;

   logic clk0 = 1'b0;
   logic clk1 = 1'b0;
   logic rstn = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int glitch_cnt = 0;
   int overlap_cnt = 0;

   clk_mux_if bus();

   clk_mux #(.SYNC_STAGES(2)) dut (
      .i_clk0 (clk0),
      .i_clk1 (clk1),
      .i_rstn (rstn),
      .bus    (bus)
   );

   // Edge grids never coincide: clk0 edges at multiples of 3.3ns,
   // clk1 edges at 1.1 + k*8.7ns.
   always #3.3 clk0 = ~clk0;
   initial begin
      #1.1;
      forever #8.7 clk1 = ~clk1;
   end

   // Phase-width monitor: no output phase shorter than the fastest
   // source half-period (3.3ns).
   realtime t_rise = 0.0, t_fall = 0.0;
   bit      have_rise = 0, have_fall = 0;
   logic    prev_o = 1'b0;
   always @(bus.o_clk) begin
      if (bus.o_clk === 1'b1 && prev_o === 1'b0) begin
         if (have_fall && ($realtime - t_fall) < 3.29) glitch_cnt++;
         t_rise = $realtime; have_rise = 1;
      end else if (bus.o_clk === 1'b0 && prev_o === 1'b1) begin
         if (have_rise && ($realtime - t_rise) < 3.29) glitch_cnt++;
         t_fall = $realtime; have_fall = 1;
      end
      prev_o = bus.o_clk;
   end

   always @(dut.en0 or dut.en1) begin
      if (dut.en0 === 1'b1 && dut.en1 === 1'b1) overlap_cnt++;
   end

   task automatic test_reset();
      int bad = 0;
      bus.i_sel = 1'b0;
      rstn = 1'b0;
      #100;
      while ($realtime < 199.0) begin
         @(clk0); #0.5;
         if (bus.o_clk !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL reset_oclk: %0d samples nonzero, required 0", bad); end
      n_cmp++;
      if (dut.en0 !== 1'b0) begin n_bad++; $display("FAIL reset_en0: got %b required 0", dut.en0); end
      n_cmp++;
      if (dut.en1 !== 1'b0) begin n_bad++; $display("FAIL reset_en1: got %b required 0", dut.en1); end
   endtask

   task automatic test_release();
      int bad = 0;
      while ($realtime < 200.0) @(negedge clk0);
      rstn = 1'b1;
      @(posedge clk0); #0.5;
      n_cmp++;
      if (dut.en0 !== 1'b0) begin n_bad++; $display("FAIL release_rise1: en0 %b required 0", dut.en0); end
      @(posedge clk0); #0.5;
      n_cmp++;
      if (dut.en0 !== 1'b0) begin n_bad++; $display("FAIL release_rise2: en0 %b required 0", dut.en0); end
      @(negedge clk0); #0.5;
      n_cmp++;
      if (dut.en0 !== 1'b1) begin n_bad++; $display("FAIL release_fall: en0 %b required 1", dut.en0); end
      repeat (5) begin
         @(posedge clk0); #1; if (bus.o_clk !== 1'b1) bad++;
         @(negedge clk0); #1; if (bus.o_clk !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL release_track0: %0d bad samples, required 0", bad); end
   endtask

   task automatic test_switch_01();
      int bad = 0;
      #10;
      @(negedge clk0);
      bus.i_sel = 1'b1;
      @(posedge clk0); #0.5;
      n_cmp++;
      if (dut.en0 !== 1'b1) begin n_bad++; $display("FAIL sw01_rise1: en0 %b required 1", dut.en0); end
      @(posedge clk0); #0.5;
      n_cmp++;
      if (dut.en0 !== 1'b1) begin n_bad++; $display("FAIL sw01_rise2: en0 %b required 1", dut.en0); end
      @(negedge clk0);
      @(posedge clk1); #0.5;
      n_cmp++;
      if ({dut.en0, dut.en1, bus.o_clk} !== 3'b000)
         begin n_bad++; $display("FAIL sw01_gap: en0,en1,o_clk %b required 000", {dut.en0, dut.en1, bus.o_clk}); end
      @(posedge clk1); #0.5;
      n_cmp++;
      if (dut.en1 !== 1'b0) begin n_bad++; $display("FAIL sw01_clk1_rise2: en1 %b required 0", dut.en1); end
      @(negedge clk1); #0.5;
      n_cmp++;
      if (dut.en1 !== 1'b1) begin n_bad++; $display("FAIL sw01_clk1_fall: en1 %b required 1", dut.en1); end
      repeat (4) begin
         @(posedge clk1); #1; if (bus.o_clk !== 1'b1) bad++;
         @(negedge clk1); #1; if (bus.o_clk !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL sw01_track1: %0d bad samples, required 0", bad); end
      n_cmp++;
      if (glitch_cnt !== 0) begin n_bad++; $display("FAIL sw01_glitch: %0d short phases, required 0", glitch_cnt); end
   endtask

   task automatic test_multi_switch();
      logic [5:0] seq = 6'b010101;  // applied LSB first: 1,0,1,0,1,0
      int bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk0);
         bus.i_sel = seq[i];
         #221;
         n_cmp++;
         if ({dut.en1, dut.en0} !== {seq[i], ~seq[i]})
            begin n_bad++; $display("FAIL multi_step%0d: en1,en0 %b required %b", i, {dut.en1, dut.en0}, {seq[i], ~seq[i]}); end
      end
      repeat (5) begin
         @(posedge clk0); #1; if (bus.o_clk !== 1'b1) bad++;
         @(negedge clk0); #1; if (bus.o_clk !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL multi_track0: %0d bad samples, required 0", bad); end
      n_cmp++;
      if (overlap_cnt !== 0) begin n_bad++; $display("FAIL multi_overlap: %0d overlaps, required 0", overlap_cnt); end
      n_cmp++;
      if (glitch_cnt !== 0) begin n_bad++; $display("FAIL multi_glitch: %0d short phases, required 0", glitch_cnt); end
   endtask

   task automatic test_short_pulse();
      int bad = 0;
      @(negedge clk0);
      bus.i_sel = 1'b1;
      #5.05;
      bus.i_sel = 1'b0;
      #200;
      n_cmp++;
      if ({dut.en1, dut.en0} !== 2'b01)
         begin n_bad++; $display("FAIL pulse_settle: en1,en0 %b required 01", {dut.en1, dut.en0}); end
      repeat (5) begin
         @(posedge clk0); #1; if (bus.o_clk !== 1'b1) bad++;
         @(negedge clk0); #1; if (bus.o_clk !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL pulse_track0: %0d bad samples, required 0", bad); end
      n_cmp++;
      if (glitch_cnt !== 0) begin n_bad++; $display("FAIL pulse_glitch: %0d short phases, required 0", glitch_cnt); end
   endtask

   task automatic test_reset_midswitch();
      int bad = 0;
      @(negedge clk0);
      bus.i_sel = 1'b1;
      @(posedge clk0); @(posedge clk0); @(negedge clk0);
      @(posedge clk1);
      @(negedge clk0);
      rstn = 1'b0;
      #60;
      n_cmp++;
      if ({dut.en1, dut.en0} !== 2'b00)
         begin n_bad++; $display("FAIL midrst_clear: en1,en0 %b required 00", {dut.en1, dut.en0}); end
      repeat (20) begin
         @(clk0); #0.5; if (bus.o_clk !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL midrst_low: %0d samples nonzero, required 0", bad); end
      @(negedge clk0);
      rstn = 1'b1;
      #150;
      n_cmp++;
      if ({dut.en1, dut.en0} !== 2'b10)
         begin n_bad++; $display("FAIL midrst_resume: en1,en0 %b required 10", {dut.en1, dut.en0}); end
      bad = 0;
      repeat (4) begin
         @(posedge clk1); #1; if (bus.o_clk !== 1'b1) bad++;
         @(negedge clk1); #1; if (bus.o_clk !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL midrst_track1: %0d bad samples, required 0", bad); end
      n_cmp++;
      if (overlap_cnt !== 0) begin n_bad++; $display("FAIL final_overlap: %0d overlaps, required 0", overlap_cnt); end
      n_cmp++;
      if (glitch_cnt !== 0) begin n_bad++; $display("FAIL final_glitch: %0d short phases, required 0", glitch_cnt); end
   endtask

   initial begin
      bus.i_sel = 1'b0;
      test_reset();
      test_release();
      test_switch_01();
      test_multi_switch();
      test_short_pulse();
      test_reset_midswitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case any wait above never returns.
   initial begin
      #20000;
      $display("FAIL timeout: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule
